// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the MEM-stage data memory access controller.
// Holds the FSM state encoding and the default timeout parameters used
// by the controller and its timeout counter.
// No ports (package).

package mem_access_ctrl_pkg;

  // Encodings are fixed so that waveforms and any external decode agree.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_TO_W    = 8;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Request/acknowledge bus between the MEM-stage controller and the
// variable-latency data memory.
// Signals:
//   mem_req_o    controller -> memory  request, level, held until ack
//   mem_we_o     controller -> memory  1 = write, 0 = read
//   mem_addr_o   controller -> memory  registered address
//   mem_wdata_o  controller -> memory  registered store data
//   mem_ack_i    memory -> controller  completion, one-cycle pulse
//   mem_rdata_i  memory -> controller  load data, valid with mem_ack_i
// Modports: master (controller side), slave (memory side).

interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/mem_access_ctrl_timeout_counter.sv
// timeout_counter
// Counts cycles spent waiting for a memory acknowledge and flags when the
// wait has reached TIMEOUT cycles.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   en       in   count this cycle
//   clr      in   synchronous clear (has priority over en)
//   expired  out  count has reached TIMEOUT

module timeout_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int TO_W    = DEFAULT_TO_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [TO_W-1:0] count;

  assign expired = (count == TO_W'(TIMEOUT));

  // The count is held once it reaches TIMEOUT so it can never wrap back
  // to zero and hide an expired wait, even if en stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + TO_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences data-memory accesses for the MEM stage of the 5-stage pipeline.
// Captures the EX/MEM access, issues a req/ack transaction on the memory
// bus, stalls the upstream pipeline and bubbles MEM/WB while the access is
// outstanding, and aborts with a sticky error if the memory never answers.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   MemRead_i      in   load in EX/MEM
//   MemWrite_i     in   store in EX/MEM (wins if both are set)
//   addr_i         in   effective address (EX/MEM ALU result)
//   wdata_i        in   store data (EX/MEM Op2)
//   mem            if   memory bus, master side
//   rdata_o        out  load data to MEM/WB
//   rdata_valid_o  out  rdata_o valid, DONE cycle of a load only
//   stall_o        out  hold PC, IF/ID, ID/EX and EX/MEM
//   bubble_o       out  force no-op controls into MEM/WB
//   err_o          out  sticky timeout flag, cleared only by reset

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = DEFAULT_TO_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  mem_access_ctrl_if.master mem,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              err_o
);

  state_t            state;
  state_t            next_state;
  logic              access;
  logic              ack;
  logic              in_req;
  logic              expired;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign access = MemRead_i | MemWrite_i;
  assign ack    = mem.mem_ack_i;
  assign in_req = (state == REQ);

  // Wait-cycle guard: counts only REQ cycles without an ack and restarts
  // for every new access because it is cleared outside REQ.
  timeout_counter #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .en      (in_req & ~ack),
    .clr     (~in_req),
    .expired (expired)
  );

  // State register. Reset abandons any in-flight access; a late ack then
  // lands in IDLE where it has no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Ack is tested before expiry so that an ack arriving
  // in the same cycle as the timeout completes the access normally.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (access) begin
          next_state = REQ;
        end
      end
      REQ: begin
        if (ack || expired) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the EX/MEM access when it is first seen so that the bus stays
  // stable for the whole request, however long memory takes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if ((state == IDLE) && access) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      we_q    <= MemWrite_i;
    end
  end

  // Load data and error capture. Stores leave rdata untouched on ack; a
  // timeout zeroes rdata so a stale value is never handed to writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (in_req) begin
      if (ack) begin
        if (!we_q) begin
          rdata_q <= mem.mem_rdata_i;
        end
      end else if (expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign mem.mem_req_o   = in_req;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state == DONE) & ~we_q;
  assign err_o         = err_q;

  // Stall is gated by reset so it drops immediately when reset is applied,
  // even while an access is still presented on the EX/MEM inputs.
  assign stall_o  = reset & (((state == IDLE) & access) | in_req);
  assign bubble_o = stall_o;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. Three controllers are built:
// index 0 with the default timeout, index 1 with TIMEOUT=4 and index 2
// with TIMEOUT=3. Only the controller chosen by sel sees accesses and
// acks; the others sit idle.

module tb_mem_access_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic        ack;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_in;
  int          sel;

  logic        req_v[3];
  logic        we_v[3];
  logic        stall_v[3];
  logic        bubble_v[3];
  logic        rvalid_v[3];
  logic        err_v[3];
  logic [31:0] addr_v[3];
  logic [31:0] wdata_v[3];
  logic [31:0] rdata_v[3];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int TO = (g == 0) ? 255 : ((g == 1) ? 4 : 3);
    mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic rd_g;
    logic wr_g;
    assign rd_g            = rd  && (sel == g);
    assign wr_g            = wr  && (sel == g);
    assign bus.mem_ack_i   = ack && (sel == g);
    assign bus.mem_rdata_i = rdata_in;
    assign req_v[g]        = bus.mem_req_o;
    assign we_v[g]         = bus.mem_we_o;
    assign addr_v[g]       = bus.mem_addr_o;
    assign wdata_v[g]      = bus.mem_wdata_o;

    mem_access_ctrl #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO),
      .TO_W    (8)
    ) dut (
      .clk           (clk),
      .reset         (rst_n),
      .MemRead_i     (rd_g),
      .MemWrite_i    (wr_g),
      .addr_i        (addr),
      .wdata_i       (wdata),
      .mem           (bus),
      .rdata_o       (rdata_v[g]),
      .rdata_valid_o (rvalid_v[g]),
      .stall_o       (stall_v[g]),
      .bubble_o      (bubble_v[g]),
      .err_o         (err_v[g])
    );
  end

  // Drives one cycle of inputs just after the falling edge, then waits a
  // little so outputs are sampled well away from the rising edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic k, input logic [31:0] rdt);
    @(negedge clk);
    rd       = r;
    wr       = w;
    addr     = a;
    wdata    = wd;
    ack      = k;
    rdata_in = rdt;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compares every output of the selected controller; bus address, data
  // and direction are only meaningful while a request is up.
  task automatic checkAll(input string tag, input logic e_req, input logic e_we,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic e_stall, input logic e_rvalid,
                          input logic [31:0] e_rdata, input logic e_err);
    checkOutput({tag, " mem_req"}, 32'(req_v[sel]), 32'(e_req));
    checkOutput({tag, " stall"}, 32'(stall_v[sel]), 32'(e_stall));
    checkOutput({tag, " bubble"}, 32'(bubble_v[sel]), 32'(e_stall));
    checkOutput({tag, " rdata_valid"}, 32'(rvalid_v[sel]), 32'(e_rvalid));
    checkOutput({tag, " rdata"}, rdata_v[sel], e_rdata);
    checkOutput({tag, " err"}, 32'(err_v[sel]), 32'(e_err));
    if (e_req) begin
      checkOutput({tag, " mem_we"}, 32'(we_v[sel]), 32'(e_we));
      checkOutput({tag, " mem_addr"}, addr_v[sel], e_addr);
      checkOutput({tag, " mem_wdata"}, wdata_v[sel], e_wdata);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic k, input logic [31:0] rdt,
                              input logic er, input logic ew, input logic [31:0] ea,
                              input logic [31:0] ewd, input logic es, input logic erv,
                              input logic [31:0] erd, input logic ee);
    vec_t v;
    v.rd = r;        v.wr = w;        v.addr = a;       v.wdata = wd;
    v.ack = k;       v.rdata = rdt;   v.e_req = er;     v.e_we = ew;
    v.e_addr = ea;   v.e_wdata = ewd; v.e_stall = es;   v.e_rvalid = erv;
    v.e_rdata = erd; v.e_err = ee;
    return v;
  endfunction

  // Watchdog so a wedged run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    ack      = 1'b0;
    addr     = '0;
    wdata    = '0;
    rdata_in = '0;
    sel      = 0;

    // Reset state of all three controllers.
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkAll($sformatf("reset%0d", s), L, L, 32'h0, 32'h0, L, L, 32'h0, L);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Load with ack in the first REQ cycle: 2 stall cycles, one valid beat.
    vecs.push_back(mk(H, L, 32'h10, 32'h0, L, 32'h0,         L, L, 32'h0,  32'h0, H, L, 32'h0, L));
    vecs.push_back(mk(H, L, 32'h10, 32'h0, H, 32'hCAFE_F00D, H, L, 32'h10, 32'h0, H, L, 32'h0, L));
    vecs.push_back(mk(H, L, 32'h10, 32'h0, L, 32'h0,         L, L, 32'h0,  32'h0, L, H, 32'hCAFE_F00D, L));
    vecs.push_back(mk(L, L, 32'h0,  32'h0, L, 32'h0,         L, L, 32'h0,  32'h0, L, L, 32'hCAFE_F00D, L));
    // Store with 5 wait cycles: 6 REQ cycles, 7 stall cycles, no valid beat.
    vecs.push_back(mk(L, H, 32'h20, 32'h1234_5678, L, 32'h0, L, L, 32'h0, 32'h0, H, L, 32'hCAFE_F00D, L));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(L, H, 32'h20, 32'h1234_5678, L, 32'h0,
                        H, H, 32'h20, 32'h1234_5678, H, L, 32'hCAFE_F00D, L));
    end
    vecs.push_back(mk(L, H, 32'h20, 32'h1234_5678, H, 32'hDEAD_BEEF,
                      H, H, 32'h20, 32'h1234_5678, H, L, 32'hCAFE_F00D, L));
    vecs.push_back(mk(L, H, 32'h20, 32'h1234_5678, L, 32'h0, L, L, 32'h0, 32'h0, L, L, 32'hCAFE_F00D, L));
    vecs.push_back(mk(L, L, 32'h0,  32'h0,         L, 32'h0, L, L, 32'h0, 32'h0, L, L, 32'hCAFE_F00D, L));
    // Back-to-back load then store (both strobes set, write wins).
    vecs.push_back(mk(H, L, 32'h40, 32'h0, L, 32'h0,         L, L, 32'h0,  32'h0, H, L, 32'hCAFE_F00D, L));
    vecs.push_back(mk(H, L, 32'h40, 32'h0, H, 32'h0BAD_F00D, H, L, 32'h40, 32'h0, H, L, 32'hCAFE_F00D, L));
    vecs.push_back(mk(H, L, 32'h40, 32'h0, L, 32'h0,         L, L, 32'h0,  32'h0, L, H, 32'h0BAD_F00D, L));
    vecs.push_back(mk(H, H, 32'h44, 32'h55AA_55AA, L, 32'h0, L, L, 32'h0, 32'h0, H, L, 32'h0BAD_F00D, L));
    vecs.push_back(mk(H, H, 32'h44, 32'h55AA_55AA, H, 32'h1111_1111,
                      H, H, 32'h44, 32'h55AA_55AA, H, L, 32'h0BAD_F00D, L));
    vecs.push_back(mk(H, H, 32'h44, 32'h55AA_55AA, L, 32'h0, L, L, 32'h0, 32'h0, L, L, 32'h0BAD_F00D, L));
    vecs.push_back(mk(L, L, 32'h0,  32'h0,         L, 32'h0, L, L, 32'h0, 32'h0, L, L, 32'h0BAD_F00D, L));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
      checkAll($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr,
               vecs[i].e_wdata, vecs[i].e_stall, vecs[i].e_rvalid, vecs[i].e_rdata, vecs[i].e_err);
    end

    // Reset asserted in the third wait cycle of a load.
    applyStimulus(H, L, 32'h100, 32'h0, L, 32'h0);
    checkAll("rst idle", L, L, 32'h0, 32'h0, H, L, 32'h0BAD_F00D, L);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(H, L, 32'h100, 32'h0, L, 32'h0);
      checkAll($sformatf("rst wait%0d", i), H, L, 32'h100, 32'h0, H, L, 32'h0BAD_F00D, L);
    end
    #1 rst_n = 1'b0;
    #1;
    checkAll("rst async", L, L, 32'h0, 32'h0, L, L, 32'h0, L);
    rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(L, L, 32'h0, 32'h0, H, 32'h7777_7777);
    checkAll("rst late ack", L, L, 32'h0, 32'h0, L, L, 32'h0, L);
    applyStimulus(L, L, 32'h0, 32'h0, L, 32'h0);
    checkAll("rst after", L, L, 32'h0, 32'h0, L, L, 32'h0, L);

    // Timeout with TIMEOUT=4: 5 REQ cycles, sticky error, rdata zeroed.
    sel = 1;
    applyStimulus(H, L, 32'h80, 32'h0, L, 32'h0);
    checkAll("to pre idle", L, L, 32'h0, 32'h0, H, L, 32'h0, L);
    applyStimulus(H, L, 32'h80, 32'h0, H, 32'hA5A5_A5A5);
    checkAll("to pre req", H, L, 32'h80, 32'h0, H, L, 32'h0, L);
    applyStimulus(H, L, 32'h80, 32'h0, L, 32'h0);
    checkAll("to pre done", L, L, 32'h0, 32'h0, L, H, 32'hA5A5_A5A5, L);
    applyStimulus(H, L, 32'h88, 32'h0, L, 32'h0);
    checkAll("to idle", L, L, 32'h0, 32'h0, H, L, 32'hA5A5_A5A5, L);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(H, L, 32'h88, 32'h0, L, 32'h0);
      checkAll($sformatf("to wait%0d", i), H, L, 32'h88, 32'h0, H, L, 32'hA5A5_A5A5, L);
    end
    applyStimulus(H, L, 32'h88, 32'h0, L, 32'h0);
    checkAll("to done", L, L, 32'h0, 32'h0, L, H, 32'h0, H);
    applyStimulus(L, L, 32'h0, 32'h0, L, 32'h0);
    checkAll("to sticky", L, L, 32'h0, 32'h0, L, L, 32'h0, H);
    applyStimulus(H, L, 32'h8C, 32'h0, L, 32'h0);
    checkAll("to next idle", L, L, 32'h0, 32'h0, H, L, 32'h0, H);
    applyStimulus(H, L, 32'h8C, 32'h0, H, 32'h600D_D00D);
    checkAll("to next req", H, L, 32'h8C, 32'h0, H, L, 32'h0, H);
    applyStimulus(H, L, 32'h8C, 32'h0, L, 32'h0);
    checkAll("to next done", L, L, 32'h0, 32'h0, L, H, 32'h600D_D00D, H);
    applyStimulus(L, L, 32'h0, 32'h0, L, 32'h0);
    checkAll("to next after", L, L, 32'h0, 32'h0, L, L, 32'h600D_D00D, H);

    // Ack and timeout together with TIMEOUT=3: ack on the 4th REQ cycle wins.
    sel = 2;
    applyStimulus(H, L, 32'hC0, 32'h0, L, 32'h0);
    checkAll("tie idle", L, L, 32'h0, 32'h0, H, L, 32'h0, L);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(H, L, 32'hC0, 32'h0, L, 32'h0);
      checkAll($sformatf("tie wait%0d", i), H, L, 32'hC0, 32'h0, H, L, 32'h0, L);
    end
    applyStimulus(H, L, 32'hC0, 32'h0, H, 32'h0F0F_0F0F);
    checkAll("tie ack", H, L, 32'hC0, 32'h0, H, L, 32'h0, L);
    applyStimulus(H, L, 32'hC0, 32'h0, L, 32'h0);
    checkAll("tie done", L, L, 32'h0, 32'h0, L, H, 32'h0F0F_0F0F, L);
    applyStimulus(L, L, 32'h0, 32'h0, L, 32'h0);
    checkAll("tie after", L, L, 32'h0, 32'h0, L, L, 32'h0F0F_0F0F, L);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
